elevator_status_encoder: RTL



---
 rtl/elev_codes_pkg.sv | 29 ++
 rtl/elev_status_prio.sv | 21 ++
 rtl/elevator_status_encoder.sv | 80 ++++++++
 3 files changed

// File: rtl/elev_codes_pkg.sv
// Display codes and phase encodings shared by the status encoder and the
// 7-segment display decoder.
package elev_codes_pkg;

  localparam logic [3:0] CODE_WAIT   = 4'd0;
  localparam logic [3:0] CODE_UP     = 4'd5;
  localparam logic [3:0] CODE_OPEN   = 4'd6;
  localparam logic [3:0] CODE_CLOSED = 4'd7;
  localparam logic [3:0] CODE_DOWN   = 4'd8;
  localparam logic [3:0] CODE_PISO   = 4'd9;

  localparam logic [1:0] PH_PISO   = 2'd0;
  localparam logic [1:0] PH_FLOOR  = 2'd1;
  localparam logic [1:0] PH_STATUS = 2'd2;

  // State values equal the phase encoding so PHASE is the state itself.
  typedef enum logic [1:0] {
    S_PISO   = 2'd0,
    S_FLOOR  = 2'd1,
    S_STATUS = 2'd2
  } disp_state_e;

  // Floors outside 1..4 display as 0.
  function automatic logic [3:0] floor_code(input logic [2:0] floor);
    if (floor >= 3'd1 && floor <= 3'd4) return {1'b0, floor};
    return CODE_WAIT;
  endfunction

endpackage

// File: rtl/elev_status_prio.sv
// Combinational priority encoder: car flags to status display code.
// Both motion flags together count as no motion and fall through.
module elev_status_prio
  import elev_codes_pkg::*;
(
  input  logic       i_moving_up,
  input  logic       i_moving_down,
  input  logic       i_door_open,
  input  logic       i_door_closed,
  output logic [3:0] o_code
);

  always_comb begin
    o_code = CODE_WAIT;
    if (i_door_open)                        o_code = CODE_OPEN;
    else if (i_moving_up && !i_moving_down) o_code = CODE_UP;
    else if (i_moving_down && !i_moving_up) o_code = CODE_DOWN;
    else if (i_door_closed)                 o_code = CODE_CLOSED;
  end

endmodule

// File: rtl/elevator_status_encoder.sv
// Cycles the display through piso marker, floor and status, each held for
// DWELL cycles; any status change jumps straight to the status phase.
module elevator_status_encoder
  import elev_codes_pkg::*;
#(
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] FLOOR,
  input  logic       MOVING_UP,
  input  logic       MOVING_DOWN,
  input  logic       DOOR_OPEN,
  input  logic       DOOR_CLOSED,
  output logic [3:0] BCD,
  output logic [1:0] PHASE
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  disp_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_status;
  logic [3:0]       r_floor;
  logic [3:0]       w_status;
  logic [3:0]       w_floor;

  elev_status_prio u_prio (
    .i_moving_up   (MOVING_UP),
    .i_moving_down (MOVING_DOWN),
    .i_door_open   (DOOR_OPEN),
    .i_door_closed (DOOR_CLOSED),
    .o_code        (w_status)
  );

  assign w_floor = floor_code(FLOOR);

  // BCD/PHASE are loaded with the code of the state being entered, so they
  // appear on the same edge that updates the state and counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= S_STATUS;
      r_cnt    <= '0;
      r_status <= CODE_WAIT;
      r_floor  <= CODE_WAIT;
      BCD      <= CODE_WAIT;
      PHASE    <= PH_STATUS;
    end else if (w_status != r_status) begin
      r_status <= w_status;
      r_state  <= S_STATUS;
      r_cnt    <= '0;
      BCD      <= w_status;
      PHASE    <= PH_STATUS;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      case (r_state)
        S_STATUS: begin
          r_state <= S_PISO;
          BCD     <= CODE_PISO;
          PHASE   <= PH_PISO;
        end
        S_PISO: begin
          r_state <= S_FLOOR;
          r_floor <= w_floor;
          BCD     <= w_floor;
          PHASE   <= PH_FLOOR;
        end
        default: begin
          r_state <= S_STATUS;
          BCD     <= r_status;
          PHASE   <= PH_STATUS;
        end
      endcase
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
